// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the PC sequencer: op encodings,
//                branch-vote modes and the sequencer FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Sequencer operation encodings (3-bit op field)
    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_J    = 3'd1,
        OP_JAL  = 3'd2,
        OP_JR   = 3'd3,
        OP_RET  = 3'd4,
        OP_BR   = 3'd5,
        OP_HALT = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    // Cross-core branch vote rules
    localparam int BR_ANY   = 0;
    localparam int BR_ALL   = 1;
    localparam int BR_CORE0 = 2;

    // Sequencer FSM states
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } seq_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/return_address_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_address_stack
//  Description : Circular return-address stack. A push into a full stack
//                overwrites the oldest entry; a pop returns the most recent
//                valid entry.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                push, push_data   - write push_data as the new top
//                pop               - discard the top entry (ignored if empty)
//                top_data          - most recent valid entry (valid if !empty)
//                empty, full       - occupancy flags
//                overflow          - push while full (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module return_address_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;   // next slot to write; top is wr_ptr-1
    logic [PTR_W:0]   count;

    assign empty    = (count == '0);
    assign full     = (count == CNT_MAX);
    assign overflow = push & full;
    assign top_data = mem[wr_ptr - PTR_W'(1)];

    // Pointer wrap is implicit because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - (PTR_W+1)'(1);
        end
    end

    // Storage is not reset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule : return_address_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer shared by lockstep cores. Handles
//                sequential fetch, J, JAL, JR, RET (via return-address
//                stack), voted conditional branch, stall and halt.
//  Ports       : clk, reset     - clock, synchronous active-high reset
//                stall          - freeze all state this cycle
//                op             - operation (cpu_pkg::op_e encoding)
//                jump_index     - J/JAL instruction index
//                branch_offset  - signed BR word offset
//                jr_addr        - JR target / RET fallback target
//                core_cond      - per-core branch conditions
//                pc_out         - current PC
//                link_addr      - return address of last JAL
//                link_valid     - pulse after an accepted JAL
//                halted         - sequencer is halted
//                ras_overflow   - pulse after JAL into a full stack
//                ras_underflow  - pulse after RET with an empty stack
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               CORES       = 4,
    parameter int               RAS_DEPTH   = 4,
    parameter int               BRANCH_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic [25:0]      jump_index,
    input  logic [15:0]      branch_offset,
    input  logic [WIDTH-1:0] jr_addr,
    input  logic [CORES-1:0] core_cond,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] link_addr,
    output logic             link_valid,
    output logic             halted,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    seq_state_e       state, state_next;
    logic [WIDTH-1:0] pc_next, link_next;
    logic             link_valid_next, ovf_next, udf_next;
    logic             accept;
    logic [WIDTH-1:0] pc4, j_target, br_target, br_off;
    logic             vote;

    logic             ras_push, ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty, ras_full, ras_ovf;
    logic             unused_ras_full;

    // ------------------------------------------------------------------
    // Target arithmetic
    // ------------------------------------------------------------------
    assign accept    = (state == ST_RUN) && !stall;
    assign pc4       = pc_out + WIDTH'(4);
    assign br_off    = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign br_target = pc4 + br_off;

    // J/JAL keep the upper region bits of pc4 when the PC is wider than 28.
    generate
        if (WIDTH > 28) begin : g_jtgt_region
            assign j_target = {pc4[WIDTH-1:28], jump_index, 2'b00};
        end else begin : g_jtgt_flat
            assign j_target = {jump_index, 2'b00};
        end
    endgenerate

    generate
        if (BRANCH_MODE == BR_ALL) begin : g_vote_all
            assign vote = &core_cond;
        end else if (BRANCH_MODE == BR_CORE0) begin : g_vote_core0
            assign vote = core_cond[0];
        end else begin : g_vote_any
            assign vote = |core_cond;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Return-address stack
    // ------------------------------------------------------------------
    return_address_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc4),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_ovf)
    );

    // Overflow already folds in the full flag.
    assign unused_ras_full = ras_full;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-PC decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        pc_next         = pc_out;
        link_next       = link_addr;
        link_valid_next = 1'b0;
        ovf_next        = 1'b0;
        udf_next        = 1'b0;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;

        if (accept) begin
            case (op_e'(op))
                OP_NEXT, OP_RSVD: pc_next = pc4;
                OP_J:             pc_next = j_target;
                OP_JAL: begin
                    pc_next         = j_target;
                    ras_push        = 1'b1;
                    link_next       = pc4;
                    link_valid_next = 1'b1;
                    ovf_next        = ras_ovf;
                end
                OP_JR:            pc_next = jr_addr;
                OP_RET: begin
                    if (ras_empty) begin
                        pc_next  = jr_addr;
                        udf_next = 1'b1;
                    end else begin
                        pc_next = ras_top;
                        ras_pop = 1'b1;
                    end
                end
                OP_BR:            pc_next = vote ? br_target : pc4;
                OP_HALT:          state_next = ST_HALTED;
                default:          pc_next = pc4;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output registers; pulses are recomputed every cycle so never held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out        <= RESET_PC;
            link_addr     <= '0;
            link_valid    <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc_out        <= pc_next;
            link_addr     <= link_next;
            link_valid    <= link_valid_next;
            ras_overflow  <= ovf_next;
            ras_underflow <= udf_next;
        end
    end

    assign halted = (state == ST_HALTED);

endmodule : pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the multi-core CPU. It replaces the fixed single-path PC update and is shared by all lockstep cores. It supports sequential fetch, J, JAL, JR, return-via-stack, conditional branch with a configurable cross-core vote, stall and halt. A return-address stack (RAS) provides single-cycle returns.

Parameters:
WIDTH, 32, PC width; must be >= 28.
RESET_PC, 0, PC value loaded on reset.
CORES, 4, number of lockstep cores supplying branch conditions.
RAS_DEPTH, 4, RAS entries; power of two, >= 2.
BRANCH_MODE, 0, vote rule: 0 = any core true, 1 = all cores true, 2 = core 0 only.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hold PC and all state this cycle; op ignored.
op  in  3  0 NEXT, 1 J, 2 JAL, 3 JR, 4 RET, 5 BR, 6 HALT, 7 reserved (treated as NEXT).
jump_index  in  26  J/JAL instruction index.
branch_offset  in  16  signed BR word offset.
jr_addr  in  WIDTH  register-sourced target for JR, and fallback target for RET.
core_cond  in  CORES  per-core branch condition.
pc_out  out  WIDTH  current PC (registered).
link_addr  out  WIDTH  registered return address from the last JAL.
link_valid  out  1  one-cycle pulse, asserted the cycle after JAL is accepted.
halted  out  1  high in HALTED state.
ras_overflow  out  1  one-cycle pulse: JAL pushed into a full RAS.
ras_underflow  out  1  one-cycle pulse: RET with empty RAS.

Behaviour:
- Reset is synchronous and active-high. On reset: pc_out=RESET_PC, link_addr=0, all pulses=0, halted=0, RAS empty, state RUN. Reset overrides stall and op.
- Define pc4 = pc_out+4, with modulo 2^WIDTH wrap.
- FSM has two states:
  - RUN to HALTED on an accepted HALT.
  - HALTED to RUN only on reset.
  - In HALTED the PC holds and all op/stall inputs are ignored.
- An op is accepted when state=RUN and stall=0. Its effect appears on pc_out at the next rising edge (latency 1).
- Next-PC rules per op:
  - NEXT: pc4.
  - J: {pc4[WIDTH-1:28], jump_index, 2'b00}.
  - JAL: same target as J. Also pushes pc4 onto the RAS, sets link_addr=pc4 and pulses link_valid.
  - JR: jr_addr.
  - RET: pops the top of the RAS. If the RAS is empty, takes jr_addr and pulses ras_underflow; the RAS stays empty.
  - BR: pc4 + (sign-extended branch_offset << 2) if the vote is true, else pc4.
  - HALT: PC holds.
- Branch vote: mode 0 = OR of core_cond, mode 1 = AND, mode 2 = core_cond[0].
- RAS is circular with pointer and count.
  - Push when count=RAS_DEPTH overwrites the oldest entry and pulses ras_overflow; count stays at RAS_DEPTH.
  - Pop returns the most recent valid entry.
- Stall: no PC, RAS, link or FSM change. All pulses are 0 during a stalled cycle.
- Pulses last exactly one cycle and are never held.
- Targets are not alignment-checked; jr_addr is passed through as given.

Decomposition:
- Shared package cpu_pkg holds:
  - op encodings OP_NEXT..OP_HALT,
  - BRANCH_MODE constants BR_ANY, BR_ALL, BR_CORE0,
  - FSM state encoding.
- One natural sub-module, return_address_stack:
  - parameters WIDTH, DEPTH;
  - ports push, pop, push_data, top_data, empty, full, overflow;
  - synchronous reset.

Test Plan:
- Reset then J with jump_index=2 -> pc_out=8 one cycle later; NEXT then gives 12.
- Starting at pc=0x100: JAL index 0x40 -> pc=0x100, link_addr=0x104, link_valid pulses once; RET at 0x100 -> pc=0x104.
- BRANCH_MODE=1, CORES=4, pc=0x20, offset=-2, core_cond=4'b1110 -> not taken, pc=0x24; same with core_cond=4'b1111 -> pc=0x1C.
- RAS_DEPTH=4: five JALs from 0x0, 0x10, 0x20, 0x30, 0x40 -> overflow pulses on the fifth. Five RETs -> 0x44, 0x34, 0x24, 0x14, then underflow pulse with pc=jr_addr=0x500.
- stall=1 held 3 cycles with op=J -> pc, link and RAS unchanged, no pulses. Deassert stall with op=J -> jump taken next cycle.
- HALT at pc=0x40 -> halted=1, pc stays 0x40 for 10 cycles of arbitrary ops. Reset asserted mid-halt -> pc=RESET_PC, halted=0, RAS empty.
